// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the Riscv151 fetch stage: PC select codes, the bubble word and FSM states.
package fetch_stage_pkg;

   localparam logic [1:0]  PcselPlus4 = 2'd0;
   localparam logic [1:0]  PcselAlu   = 2'd1;
   localparam logic [31:0] InstNop    = 32'h0000_0013;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHeld = 2'd2,
      StKill = 2'd3
   } fetch_state_e;

   // Codes 2 and 3 are reserved and fall through to sequential fetch.
   function automatic logic is_redirect(input logic [1:0] pc_sel);
      return pc_sel == PcselAlu;
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and the fetch/decode/execute PC registers.
module fetch_pc_gen #(
   parameter logic [31:0] ResetPc = 32'h0000_2000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        advance_i,
   input  logic        redirect_i,
   input  logic [31:0] alu_target_i,
   output logic [31:0] pc_f_o,
   output logic [31:0] pc_i_o,
   output logic [31:0] pc_x_o
);

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_i_q, pc_i_d;
   logic [31:0] pc_x_q, pc_x_d;

   always_comb begin
      pc_f_d = pc_f_q;
      if (!stall_i && redirect_i) begin
         pc_f_d = alu_target_i;
      end else if (advance_i) begin
         pc_f_d = pc_f_q + 32'd4;
      end
      pc_i_d = advance_i ? pc_f_q : pc_i_q;
      pc_x_d = stall_i ? pc_x_q : pc_i_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_f_q <= ResetPc;
         pc_i_q <= '0;
         pc_x_q <= '0;
      end else begin
         pc_f_q <= pc_f_d;
         pc_i_q <= pc_i_d;
         pc_x_q <= pc_x_d;
      end
   end

   assign pc_f_o = pc_f_q;
   assign pc_i_o = pc_i_q;
   assign pc_x_o = pc_x_q;

endmodule

// File: rtl/fetch_stage.sv
// Stage I of the 3-stage pipeline: drives the ICache, inserts bubbles and holds the word on stalls.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] ResetPc    = 32'h0000_2000,
   parameter logic [31:0] NopInst    = InstNop,
   parameter int unsigned KillCycles = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  pc_sel_i,
   input  logic [31:0] alu_target_i,
   input  logic        stall_i,
   output logic [31:0] icache_addr_o,
   output logic        icache_re_o,
   input  logic [31:0] icache_dout_i,
   input  logic        icache_stall_i,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic [31:0] pc_i_o,
   output logic [31:0] pc_x_o
);

   localparam logic [1:0] KillInit = 2'(KillCycles);

   fetch_state_e state_q;
   logic [31:0]  hold_q;
   logic [1:0]   kill_cnt_q;
   logic         redirect;
   logic         advance;
   logic [31:0]  pc_f;

   assign redirect = !stall_i && is_redirect(pc_sel_i);
   // A held word is already captured, so a not-ready ICache cannot block its release.
   assign advance  = !stall_i && ((state_q == StHeld) || !icache_stall_i);

   fetch_pc_gen #(
      .ResetPc(ResetPc)
   ) u_pc_gen (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .stall_i     (stall_i),
      .advance_i   (advance),
      .redirect_i  (redirect),
      .alu_target_i(alu_target_i),
      .pc_f_o      (pc_f),
      .pc_i_o      (pc_i_o),
      .pc_x_o      (pc_x_o)
   );

   assign icache_addr_o = pc_f;
   assign icache_re_o   = !stall_i;

   always_comb begin
      inst_o       = NopInst;
      inst_valid_o = 1'b0;
      unique case (state_q)
         StBoot, StKill: begin
            inst_o       = NopInst;
            inst_valid_o = 1'b0;
         end
         StRun: begin
            inst_o       = icache_stall_i ? NopInst : icache_dout_i;
            inst_valid_o = !icache_stall_i;
         end
         StHeld: begin
            inst_o       = hold_q;
            inst_valid_o = 1'b1;
         end
         default: ;
      endcase
   end

   // A stall that lands while the ICache is still busy stays in RUN: nothing valid to capture,
   // and the outstanding word is picked up once the ICache delivers it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StBoot;
         hold_q     <= NopInst;
         kill_cnt_q <= '0;
      end else if (stall_i) begin
         if (state_q == StRun && !icache_stall_i) begin
            state_q <= StHeld;
            hold_q  <= icache_dout_i;
         end
      end else if (redirect) begin
         state_q    <= StKill;
         kill_cnt_q <= KillInit;
      end else begin
         unique case (state_q)
            StBoot: if (!icache_stall_i) state_q <= StRun;
            StRun:  ;
            StHeld: state_q <= StRun;
            StKill: begin
               if (!icache_stall_i) begin
                  kill_cnt_q <= kill_cnt_q - 2'd1;
                  if (kill_cnt_q <= 2'd1) state_q <= StRun;
               end
            end
            default: state_q <= StBoot;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and random traffic.
module tb_fetch_stage;

   localparam logic [31:0] Nop  = 32'h0000_0013;
   localparam int          Kill = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  pc_sel;
   logic [31:0] alu_target;
   logic        stall;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] icache_dout;
   logic        icache_stall;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc_i;
   logic [31:0] pc_x;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pc_sel_i      (pc_sel),
      .alu_target_i  (alu_target),
      .stall_i       (stall),
      .icache_addr_o (icache_addr),
      .icache_re_o   (icache_re),
      .icache_dout_i (icache_dout),
      .icache_stall_i(icache_stall),
      .inst_o        (inst),
      .inst_valid_o  (inst_valid),
      .pc_i_o        (pc_i),
      .pc_x_o        (pc_x)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: fetch pointer, PC of the word the ICache owes us, kill budget, held word.
   logic [31:0] m_pcf, m_pci, m_pcx, m_held_word;
   bit          m_has_resp, m_held;
   int          m_squash;

   logic [31:0] obs_addr, obs_inst, obs_pci;
   logic        obs_valid;

   typedef struct {
      logic        st;
      logic [1:0]  sel;
      logic [31:0] tgt;
      logic        ist;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic        e_valid;
      logic [31:0] e_pci;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_2004) return 32'h0050_0093;
      return {1'b1, a[30:0]} ^ 32'h0000_0F0F;
   endfunction

   function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic [31:0] tgt,
                               input logic ist, input logic [31:0] e_addr,
                               input logic [31:0] e_inst, input logic e_valid,
                               input logic [31:0] e_pci);
      vec_t v;
      v.st = st; v.sel = sel; v.tgt = tgt; v.ist = ist;
      v.e_addr = e_addr; v.e_inst = e_inst; v.e_valid = e_valid; v.e_pci = e_pci;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pcf = 32'h0000_2000; m_pci = '0; m_pcx = '0;
      m_has_resp = 0; m_held = 0; m_squash = 0; m_held_word = Nop;
   endtask

   task automatic model_expect(output logic [31:0] e_inst, output logic e_valid);
      if (m_held) begin
         e_inst = m_held_word; e_valid = 1'b1;
      end else if (!m_has_resp || icache_stall || m_squash > 0) begin
         e_inst = Nop; e_valid = 1'b0;
      end else begin
         e_inst = mem_word(m_pci); e_valid = 1'b1;
      end
   endtask

   task automatic model_step(input logic st, input logic [1:0] sel, input logic [31:0] tgt,
                             input logic ist);
      bit redir;
      bit adv;
      redir = !st && (sel == 2'd1);
      if (st) begin
         if (!m_held && m_has_resp && m_squash == 0 && !ist) begin
            m_held = 1; m_held_word = mem_word(m_pci);
         end
      end else begin
         adv   = m_held || !ist;
         m_pcx = m_pci;
         if (adv) m_pci = m_pcf;
         if (redir) begin
            m_pcf = tgt; m_squash = Kill; m_has_resp = 1;
         end else begin
            if (adv) m_pcf = m_pcf + 32'd4;
            if (m_squash > 0 && !ist) m_squash--;
            if (!ist) m_has_resp = 1;
         end
         m_held = 0;
      end
   endtask

   task automatic run_cycle(input logic st, input logic [1:0] sel, input logic [31:0] tgt,
                            input logic ist);
      logic [31:0] e_inst;
      logic        e_valid;
      stall = st; pc_sel = sel; alu_target = tgt; icache_stall = ist;
      icache_dout = (m_held || !m_has_resp || ist) ? $urandom : mem_word(m_pci);
      @(negedge clk);
      model_expect(e_inst, e_valid);
      check32("addr", icache_addr, m_pcf);
      check32("re", {31'b0, icache_re}, {31'b0, !st});
      check32("inst", inst, e_inst);
      check32("valid", {31'b0, inst_valid}, {31'b0, e_valid});
      check32("pc_i", pc_i, m_pci);
      check32("pc_x", pc_x, m_pcx);
      obs_addr = icache_addr; obs_inst = inst; obs_valid = inst_valid; obs_pci = pc_i;
      @(posedge clk);
      model_step(st, sel, tgt, ist);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 0; pc_sel = 0; alu_target = 0; icache_stall = 0;
      icache_dout = $urandom;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = mk(0, 0, 0,            0, 32'h2000, Nop,                 0, 32'h0);
      vecs[1]  = mk(0, 0, 0,            0, 32'h2004, mem_word(32'h2000),  1, 32'h2000);
      vecs[2]  = mk(1, 0, 0,            0, 32'h2008, 32'h0050_0093,       1, 32'h2004);
      vecs[3]  = mk(1, 0, 0,            0, 32'h2008, 32'h0050_0093,       1, 32'h2004);
      vecs[4]  = mk(1, 0, 0,            0, 32'h2008, 32'h0050_0093,       1, 32'h2004);
      vecs[5]  = mk(0, 1, 32'h2100,     0, 32'h2008, 32'h0050_0093,       1, 32'h2004);
      vecs[6]  = mk(0, 0, 0,            0, 32'h2100, Nop,                 0, 32'h2008);
      vecs[7]  = mk(0, 0, 0,            0, 32'h2104, mem_word(32'h2100),  1, 32'h2100);
      vecs[8]  = mk(0, 0, 0,            1, 32'h2108, Nop,                 0, 32'h2104);
      vecs[9]  = mk(0, 0, 0,            1, 32'h2108, Nop,                 0, 32'h2104);
      vecs[10] = mk(0, 0, 0,            0, 32'h2108, mem_word(32'h2104),  1, 32'h2104);
      vecs[11] = mk(0, 0, 0,            0, 32'h210C, mem_word(32'h2108),  1, 32'h2108);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         run_cycle(vecs[i].st, vecs[i].sel, vecs[i].tgt, vecs[i].ist);
         check32($sformatf("vec%0d_addr", i), obs_addr, vecs[i].e_addr);
         check32($sformatf("vec%0d_inst", i), obs_inst, vecs[i].e_inst);
         check32($sformatf("vec%0d_valid", i), {31'b0, obs_valid}, {31'b0, vecs[i].e_valid});
         check32($sformatf("vec%0d_pc_i", i), obs_pci, vecs[i].e_pci);
      end

      // Back-to-back redirects: the 0x3000 stream must never surface.
      run_cycle(0, 1, 32'h3000, 0);
      run_cycle(0, 1, 32'h4000, 0);
      run_cycle(0, 0, 0, 0);
      check32("b2b_addr", obs_addr, 32'h4000);
      check32("b2b_bubble", {31'b0, obs_valid}, 32'h0);
      run_cycle(0, 0, 0, 0);
      check32("b2b_inst", obs_inst, mem_word(32'h4000));
      check32("b2b_pc_i", obs_pci, 32'h4000);

      // Sequential fetch wraps past the top of the address space.
      run_cycle(0, 1, 32'hFFFF_FFF8, 0);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      check32("wrap_addr", obs_addr, 32'h0);
      check32("wrap_pc_i", obs_pci, 32'hFFFF_FFFC);

      // Asynchronous reset in the middle of a stream.
      do_reset();
      for (int i = 0; i < 16; i++) run_cycle(0, 0, 0, 0);
      check32("pre_reset_addr", icache_addr, 32'h2040);
      #2;
      rst_n = 1'b0;
      #1;
      check32("rst_addr", icache_addr, 32'h2000);
      check32("rst_inst", inst, Nop);
      check32("rst_valid", {31'b0, inst_valid}, 32'h0);
      check32("rst_pc_i", pc_i, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_cycle(0, 0, 0, 0);
      check32("restart_addr", obs_addr, 32'h2000);
      run_cycle(0, 0, 0, 0);
      check32("restart_inst", obs_inst, mem_word(32'h2000));

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic [1:0]  sel;
         logic [31:0] tgt;
         int          r;
         r   = $urandom_range(0, 9);
         sel = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h000F_FFFC);
         run_cycle(($urandom_range(0, 3) == 0), sel, tgt, ($urandom_range(0, 4) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
